// File: rtl/frame_buffer_dbl.sv
// frame_buffer_dbl: double-buffered pixel store, streaming writer into the back page, registered reader on the front page; define FB_DROP_EN to drop beats while a frame is pending instead of overwriting it
module frame_buffer_dbl #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int COLOR_W = 12,
    parameter int ADDR_W  = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_sof,
    input  logic               wr_valid,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               wr_ready,
    input  logic               rd_vsync,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COLOR_W-1:0] rd_data,
    output logic               front_page,
    output logic               frame_pending,
    output logic [15:0]        ovf_cnt
);
    localparam int NPIX = H_RES * V_RES;
    localparam int PW = NPIX > 1 ? $clog2(NPIX) : 1;
    localparam logic [PW-1:0] LAST = PW'(NPIX - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      wp_q, wp_d, wr_idx;
    logic               front_q, front_d, ovf_inc, acc, swap, wr_page;
    logic [15:0]        ovf_q, ovf_d;
    logic [COLOR_W-1:0] rd_data_q;
    logic [COLOR_W-1:0] mem [0:1][0:NPIX-1];

    assign acc           = wr_valid && wr_ready;
    assign swap          = rd_vsync && state_q == HOLD;
    assign front_page    = front_q;
    assign frame_pending = state_q == HOLD;
    assign ovf_cnt       = ovf_q;
    assign rd_data       = rd_data_q;

    // State and counters; a reset abandons any partial frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            wp_q    <= '0;
            front_q <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            front_q <= front_d;
            ovf_q   <= ovf_d;
        end
    end

    // HOLD leaves on a swap or on an overwriting beat; FILL completes on the last non-sof pixel
    always_comb begin
        state_d = state_q == HOLD ? ((swap || acc) ? FILL : HOLD)
                                  : ((acc && !wr_sof && wp_q == LAST) ? HOLD : FILL);
    end

    // Write side control: a swap in the same cycle redirects the beat to the page just released
    always_comb begin
`ifdef FB_DROP_EN
        wr_ready = state_q == FILL;
        ovf_inc  = state_q == HOLD && wr_valid;
`else
        wr_ready = 1'b1;
        ovf_inc  = state_q == HOLD && wr_valid && !swap;
`endif
        wr_page = ~(front_q ^ swap);
        wr_idx  = (state_q == HOLD || wr_sof) ? '0 : wp_q;
        wp_d    = !acc ? (swap ? '0 : wp_q)
                       : (state_q == HOLD || wr_sof) ? PW'(1)
                       : (wp_q == LAST ? '0 : wp_q + PW'(1));
        front_d = front_q ^ swap;
        ovf_d   = (ovf_inc && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
    end

    // Pixel storage write port; contents survive reset
    always_ff @(posedge clk) begin
        if (acc && !reset) mem[wr_page][wr_idx] <= wr_data;
    end

    // Registered read of the front page, zero beyond the frame
    always_ff @(posedge clk) begin
        if (reset) rd_data_q <= '0;
        else rd_data_q <= (32'(rd_addr) >= NPIX) ? '0 : mem[front_q][rd_addr[PW-1:0]];
    end
endmodule

// File: tb/tb_frame_buffer_dbl.sv
// tb_frame_buffer_dbl: random and directed stimulus checked every cycle against a page/queue level model
module tb_frame_buffer_dbl;
    localparam int H = 8, V = 4, N = H * V, AW = 6, CW = 12;
`ifdef FB_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 0, reset = 1, wr_sof = 0, wr_valid = 0, rd_vsync = 0;
    logic [CW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          wr_ready, front_page, frame_pending;
    logic [CW-1:0] rd_data;
    logic [15:0]   ovf_cnt;

    int checks = 0, fails = 0;
    bit chk = 0;

    logic [CW-1:0] m [2][N];
    bit            kn [2][N];
    bit            m_front, m_pend, e_kn, m_swap, m_acc;
    int            m_wp, m_ovf, m_a, ra;
    logic [CW-1:0] e_rd, p0, d0;

    frame_buffer_dbl #(.H_RES(H), .V_RES(V), .COLOR_W(CW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_vsync(rd_vsync), .rd_addr(rd_addr), .rd_data(rd_data),
        .front_page(front_page), .frame_pending(frame_pending), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: two pages as arrays, a pending flag and a fill index
    always @(posedge clk) begin
        if (reset) begin
            m_front = 0; m_pend = 0; m_wp = 0; m_ovf = 0; e_rd = '0; e_kn = 1;
        end else begin
            ra = int'(rd_addr);
            e_kn = ra >= N ? 1'b1 : kn[m_front][ra];
            e_rd = ra >= N ? '0 : m[m_front][ra];
            m_acc = wr_valid && !(DROP && m_pend);
            m_swap = rd_vsync && m_pend;
            if (DROP && m_pend && wr_valid && m_ovf < 65535) m_ovf++;
            if (m_swap) begin
                m_front = !m_front; m_pend = 0; m_wp = 0;
            end
            if (m_acc) begin
                if (m_pend) begin
                    if (m_ovf < 65535) m_ovf++;
                    m_pend = 0; m_a = 0; m_wp = 1;
                end else if (wr_sof) begin
                    m_a = 0; m_wp = 1;
                end else begin
                    m_a = m_wp; m_wp++;
                    if (m_wp == N) begin m_wp = 0; m_pend = 1; end
                end
                m[!m_front][m_a] = wr_data;
                kn[!m_front][m_a] = 1;
            end
        end
    end

    always @(negedge clk) if (chk) begin
        check("wr_ready", wr_ready, !(DROP && m_pend));
        check("front_page", front_page, m_front);
        check("frame_pending", frame_pending, m_pend);
        check("ovf_cnt", ovf_cnt, m_ovf);
        if (e_kn) check("rd_data", rd_data, e_rd);
    end

    task automatic beat(input bit sof, input logic [CW-1:0] d, input bit vs);
        wr_valid = 1; wr_sof = sof; wr_data = d; rd_vsync = vs;
        rd_addr = AW'($urandom_range(0, 2**AW - 1));
        @(negedge clk);
        wr_valid = 0; wr_sof = 0; rd_vsync = 0;
    endtask

    task automatic idle(input bit vs, input logic [AW-1:0] a);
        rd_vsync = vs; rd_addr = a;
        @(negedge clk);
        rd_vsync = 0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset = 0; chk = 1;
        check("rst_rd_data", rd_data, 0);
        check("rst_front", front_page, 0);
        check("rst_pending", frame_pending, 0);
        check("rst_ready", wr_ready, 1);
        for (int i = 0; i < N; i++) beat(i == 0, CW'(12'hBE0 + i), 0);
        check("f1_pending", frame_pending, 1);
        idle(1, 0);
        idle(0, 0);
        check("f1_front", front_page, 1);
        check("f1_px0", rd_data, 12'hBE0);
        idle(0, 1);
        check("f1_px1", rd_data, 12'hBE1);
        idle(0, AW'(N - 1));
        check("f1_last", rd_data, 12'hBFF);
        idle(0, AW'(N + 8));
        check("f1_oob", rd_data, 0);
        idle(1, 5);
        check("nopend_front", front_page, 1);
        check("nopend_rd", rd_data, 12'hBE5);
        for (int i = 0; i < N; i++) beat(i == 0, CW'($urandom), i == N - 1);
        check("coinc_pending", frame_pending, 1);
        check("coinc_front", front_page, 1);
        idle(1, 0);
        check("coinc_swap", front_page, 0);
        p0 = CW'($urandom);
        for (int i = 0; i < N; i++) beat(i == 0, i == 0 ? p0 : CW'($urandom), 0);
        d0 = ~p0;
        beat(0, d0, 0);
        for (int k = 1; k < 10; k++) beat(0, CW'($urandom), 0);
`ifdef FB_DROP_EN
        check("ovf_cnt_drop", ovf_cnt, 10);
        check("ovf_ready_drop", wr_ready, 0);
`else
        check("ovf_cnt_over", ovf_cnt, 1);
        for (int k = 10; k < N; k++) beat(0, CW'($urandom), 0);
`endif
        idle(1, 0);
        idle(0, 0);
        check("ovf_px0", rd_data, DROP ? p0 : d0);
        for (int i = 0; i < 10; i++) beat(i == 0, CW'($urandom), 0);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid_rst_front", front_page, 0);
        check("mid_rst_pending", frame_pending, 0);
        for (int i = 0; i < N - 1; i++) beat(0, CW'(12'h100 + i), 0);
        check("mid_rst_not_yet", frame_pending, 0);
        beat(0, CW'(12'h100 + N - 1), 0);
        check("mid_rst_full", frame_pending, 1);
        idle(1, 0);
        idle(0, 3);
        check("mid_rst_front1", front_page, 1);
        check("mid_rst_px3", rd_data, 12'h103);
        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(0, 499) == 0;
            wr_valid = $urandom_range(0, 3) != 0;
            wr_sof = $urandom_range(0, 63) == 0;
            rd_vsync = $urandom_range(0, 15) == 0;
            wr_data = CW'($urandom);
            rd_addr = AW'($urandom_range(0, 2**AW - 1));
            @(negedge clk);
        end
        reset = 0; wr_valid = 0; wr_sof = 0; rd_vsync = 0;
        @(negedge clk);
        chk = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
